// File: rtl/boot_ctrl.sv
`default_nettype none
// ============================================================================
// boot_ctrl : streams a program image into CPU memory, then runs it to halt
// Revision  : 1.0
// ============================================================================
module boot_ctrl #(
  parameter int MEMSIZE = 64,
  parameter int ADDR_W  = 6,
  parameter int CNT_W   = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              cpu_halt,
  input  logic              cpu_wr_flag,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [7:0]        cpu_wr_value,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic [1:0]        state,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  run_cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   MAX_LEN = (ADDR_W + 1)'(MEMSIZE);
  localparam logic [ADDR_W:0]   LEN_ONE = 1;
  localparam logic [ADDR_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0]  RUN_ONE = 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic              err_q, err_d;

  logic len_legal;
  logic last_byte;

  assign len_legal = (load_len != '0) && (load_len <= MAX_LEN);
  assign last_byte = (({1'b0, cnt_q} + LEN_ONE) == len_q);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    run_d     = run_q;
    err_d     = 1'b0;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          if (len_legal) begin
            state_d = S_LOAD;
            len_d   = load_len;
            cnt_d   = '0;
            run_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      // Only the loader reaches memory here; CPU write inputs are dropped.
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_addr  = cnt_q;
          mem_wdata = in_data;
          if (last_byte) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      S_RUN: begin
        mem_we = cpu_wr_flag;
        if (cpu_wr_flag) begin
          mem_addr  = cpu_wr_addr;
          mem_wdata = cpu_wr_value;
        end
        if (run_q != '1) begin
          run_d = run_q + RUN_ONE;
        end
        if (cpu_halt) begin
          state_d = S_HALT;
        end
      end

      default: begin
      end
    endcase
  end

  assign cpu_reset  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign done       = (state_q == S_HALT);
  assign state      = state_q;
  assign err        = err_q;
  assign run_cycles = run_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_ctrl.sv
`default_nettype none
// ============================================================================
// tb_boot_ctrl : randomized bench for boot_ctrl against a behavioural model
// Revision     : 1.0
// ============================================================================
module tb_boot_ctrl;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0;
  logic [6:0] load_len = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       cpu_halt = 1'b0;
  logic       cpu_wr_flag = 1'b0;
  logic [5:0] cpu_wr_addr = '0;
  logic [7:0] cpu_wr_value = '0;

  logic        in_ready, mem_we, cpu_reset, done, err;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [1:0]  state;
  logic [15:0] run_cycles;

  logic        s_in_ready, s_mem_we, s_cpu_reset, s_done, s_err;
  logic [5:0]  s_mem_addr;
  logic [7:0]  s_mem_wdata;
  logic [1:0]  s_state;
  logic [3:0]  s_run_cycles;

  boot_ctrl #(.MEMSIZE(64), .ADDR_W(6), .CNT_W(16)) dut (
    .CLOCK(clk), .RESET(RESET), .start(start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_halt(cpu_halt), .cpu_wr_flag(cpu_wr_flag), .cpu_wr_addr(cpu_wr_addr),
    .cpu_wr_value(cpu_wr_value), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .state(state), .done(done),
    .err(err), .run_cycles(run_cycles)
  );

  // Narrow counter copy shares all inputs so saturation is seen on a short run.
  boot_ctrl #(.MEMSIZE(64), .ADDR_W(6), .CNT_W(4)) dut_s (
    .CLOCK(clk), .RESET(RESET), .start(start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .cpu_halt(cpu_halt), .cpu_wr_flag(cpu_wr_flag), .cpu_wr_addr(cpu_wr_addr),
    .cpu_wr_value(cpu_wr_value), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .cpu_reset(s_cpu_reset), .state(s_state), .done(s_done),
    .err(s_err), .run_cycles(s_run_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rst_cnt = 0;

  logic [7:0] exp_mem [64];
  logic [7:0] dut_mem [64];

  // Model: phase 0 idle, 1 load, 2 run, 3 halt; load tracked as bytes still owed.
  int m_state = 0;
  int m_len   = 0;
  int m_left  = 0;
  int m_run   = 0;
  bit m_err   = 1'b0;

  always @(posedge RESET) rst_cnt++;

  always @(posedge clk) begin
    if (mem_we === 1'b1) dut_mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_dut(input string tag, input logic [1:0] st, input logic dn,
                           input logic er, input logic rdy, input logic we,
                           input logic crst, input logic [5:0] addr,
                           input logic [7:0] data, input logic [15:0] rc,
                           input int rc_max);
    bit       e_we;
    int       e_addr;
    int       e_data;
    e_we   = (m_state == 1 && in_valid) || (m_state == 2 && cpu_wr_flag);
    e_addr = (m_state == 1) ? (m_len - m_left) : int'(cpu_wr_addr);
    e_data = (m_state == 1) ? int'(in_data) : int'(cpu_wr_value);
    chk({tag, "_ctl"}, {st, dn, er, rdy, we, crst},
        {2'(m_state), m_state == 3, m_err, m_state == 1, e_we, m_state < 2});
    chk({tag, "_run_cycles"}, rc, (m_run > rc_max) ? rc_max : m_run);
    if (e_we) chk({tag, "_wr"}, {addr, data}, {6'(e_addr), 8'(e_data)});
    else      chk({tag, "_wr_known"}, 32'($isunknown({addr, data})), 0);
  endtask

  initial begin : compare
    int seen;
    bit legal;
    seen = 0;
    forever begin
      @(negedge clk);
      if (RESET || rst_cnt != seen) begin
        seen    = rst_cnt;
        m_state = 0;
        m_len   = 0;
        m_left  = 0;
        m_run   = 0;
        m_err   = 1'b0;
      end
      if (!RESET) begin
        check_dut("main", state, done, err, in_ready, mem_we, cpu_reset,
                  mem_addr, mem_wdata, run_cycles, 65535);
        check_dut("small", s_state, s_done, s_err, s_in_ready, s_mem_we, s_cpu_reset,
                  s_mem_addr, s_mem_wdata, {12'h0, s_run_cycles}, 15);
        legal = (load_len >= 1) && (load_len <= 64);
        m_err = (m_state == 0 || m_state == 3) && start && !legal;
        case (m_state)
          0, 3: if (start && legal) begin
            m_state = 1;
            m_len   = int'(load_len);
            m_left  = int'(load_len);
            m_run   = 0;
          end
          1: if (in_valid) begin
            exp_mem[m_len - m_left] = in_data;
            m_left--;
            if (m_left == 0) m_state = 2;
          end
          2: begin
            m_run++;
            if (cpu_wr_flag) exp_mem[cpu_wr_addr] = cpu_wr_value;
            if (cpu_halt) m_state = 3;
          end
          default: ;
        endcase
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    start        = 1'b0;
    in_valid     = 1'b0;
    cpu_halt     = 1'b0;
    cpu_wr_flag  = 1'b0;
    in_data      = 8'($urandom);
    cpu_wr_addr  = 6'($urandom);
    cpu_wr_value = 8'($urandom);
    load_len     = 7'($urandom);
  endtask

  task automatic do_load(input int len, input bit gaps);
    int sent;
    int guard;
    start    = 1'b1;
    load_len = 7'(len);
    tick();
    sent  = 0;
    guard = 0;
    while (sent < len && guard < 2000) begin
      in_valid     = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data      = 8'($urandom);
      cpu_wr_flag  = 1'($urandom);
      cpu_wr_addr  = 6'($urandom);
      cpu_wr_value = 8'($urandom);
      start        = ($urandom_range(0, 3) == 0);
      load_len     = 7'($urandom_range(1, 64));
      tick();
      if (in_valid) sent++;
      guard++;
    end
    idle_inputs();
  endtask

  task automatic do_run(input int n, input int wr_pct);
    for (int i = 0; i < n; i++) begin
      cpu_wr_flag  = ($urandom_range(0, 99) < wr_pct);
      cpu_wr_addr  = 6'($urandom);
      cpu_wr_value = 8'($urandom);
      cpu_halt     = (i == n - 1);
      in_valid     = 1'($urandom);
      in_data      = 8'($urandom);
      start        = 1'($urandom);
      load_len     = 7'($urandom_range(1, 64));
      tick();
    end
    idle_inputs();
  endtask

  task automatic halt_noise(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_wr_flag  = 1'($urandom);
      cpu_wr_addr  = 6'($urandom);
      cpu_wr_value = 8'($urandom);
      in_valid     = 1'($urandom);
      tick();
    end
    idle_inputs();
  endtask

  initial begin : stim
    logic [7:0] img [4];
    bit         pat [6];
    int         k;
    img = '{8'h40, 8'h01, 8'h50, 8'h02};
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 64; i++) begin
      exp_mem[i] = 8'h00;
      dut_mem[i] = 8'h00;
    end

    tick(); tick(); tick();
    RESET = 1'b0;
    tick();
    chk("reset_state", state, 0);
    chk("reset_cpu_reset", cpu_reset, 1);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_run_cycles", run_cycles, 0);
    chk("reset_err", err, 0);

    // Illegal lengths from IDLE
    start = 1'b1; load_len = 7'd0; tick(); start = 1'b0;
    #1 chk("err_len0", {state, err}, {2'd0, 1'b1});
    tick();
    #1 chk("err_len0_clear", err, 0);
    start = 1'b1; load_len = 7'd65; tick(); start = 1'b0;
    #1 chk("err_len65", {state, err, mem_we}, {2'd0, 1'b1, 1'b0});
    tick();
    #1 chk("err_len65_clear", err, 0);

    // Gapped four-byte load
    start = 1'b1; load_len = 7'd4; tick(); start = 1'b0;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i];
      in_data  = pat[i] ? img[k] : 8'hEE;
      #1 if (pat[i]) chk("gap_load_addr", {mem_we, mem_addr}, {1'b1, 6'(k)});
      else           chk("gap_load_idle", mem_we, 0);
      tick();
      if (pat[i]) k++;
    end
    idle_inputs();
    chk("load4_to_run", {state, cpu_reset}, {2'd2, 1'b0});

    // Twenty RUN cycles: CPU write while a loader byte is offered, halt with write
    for (int i = 0; i < 20; i++) begin
      cpu_halt    = (i == 19);
      cpu_wr_flag = (i == 0) || (i == 19);
      cpu_wr_addr = (i == 0) ? 6'd63 : 6'd62;
      cpu_wr_value = (i == 0) ? 8'h01 : 8'hAA;
      in_valid    = (i == 0);
      in_data     = 8'h77;
      #1 if (i == 0)  chk("run_passthru", {mem_we, mem_addr, mem_wdata, in_ready},
                          {1'b1, 6'd63, 8'h01, 1'b0});
      else if (i == 19) chk("halt_cycle_write", {mem_we, mem_addr, mem_wdata},
                            {1'b1, 6'd62, 8'hAA});
      tick();
    end
    idle_inputs();
    chk("halt_state", {state, done}, {2'd3, 1'b1});
    chk("halt_run_cycles", run_cycles, 20);
    chk("sat_run_cycles", s_run_cycles, 15);
    cpu_wr_flag = 1'b1;
    #1 chk("halt_no_write", mem_we, 0);
    tick();
    idle_inputs();
    chk("mem_image_literal", {dut_mem[0], dut_mem[1], dut_mem[2], dut_mem[3], dut_mem[62], dut_mem[63]},
        {8'h40, 8'h01, 8'h50, 8'h02, 8'hAA, 8'h01});
    halt_noise(5);

    // Illegal start in HALT
    start = 1'b1; load_len = 7'd100; tick(); start = 1'b0;
    #1 chk("halt_err", {state, err}, {2'd3, 1'b1});
    tick();

    // Full reload from HALT
    start = 1'b1; load_len = 7'd64; tick(); start = 1'b0;
    #1 chk("reload_enter", {state, cpu_reset, run_cycles}, {2'd1, 1'b1, 16'd0});
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
    end
    idle_inputs();
    chk("reload64_run", state, 2);
    do_run(30, 40);

    // Async reset in the middle of a ten-byte load
    start = 1'b1; load_len = 7'd10; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom); tick();
    end
    in_valid = 1'b0;
    RESET = 1'b1;
    #1 chk("async_reset", {state, cpu_reset, in_ready}, {2'd0, 1'b1, 1'b0});
    RESET = 1'b0;
    tick();
    do_load(4, 0);
    chk("post_reset_load", state, 2);
    do_run(6, 50);

    // Randomized sessions from HALT
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        start    = 1'b1;
        load_len = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(65, 127));
        tick();
        idle_inputs();
        tick();
      end else begin
        do_load($urandom_range(1, 64), 1'b1);
        do_run($urandom_range(1, 40), 40);
      end
      halt_noise($urandom_range(1, 4));
    end

    tick();
    for (int i = 0; i < 64; i++) chk($sformatf("mem_image_%0d", i), dut_mem[i], exp_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boot_ctrl.md
Name: boot_ctrl

Overview:
- Boot and run sequencer for the 8-bit CPU and its 64-byte program/data memory.
- Holds the CPU in reset while a program image is streamed into memory over a valid/ready byte interface, then releases the CPU.
- Owns the memory write port: the loader drives it during load, the CPU drives it during run.
- Detects halt, freezes memory writes, reports a run-cycle count; replaces file-based memory preload for synthesizable targets.

Parameters:
- MEMSIZE, 64, memory depth in bytes (power of two, ≤ 128)
- ADDR_W, 6, log2(MEMSIZE)
- CNT_W, 16, run-cycle counter width

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a load
- load_len  in  ADDR_W+1  bytes to load; sampled with start
- in_valid  in  1  loader byte valid
- in_data  in  8  loader byte
- in_ready  out  1  loader byte accepted when in_valid & in_ready
- cpu_halt  in  1  CPU decoded hlt this cycle
- cpu_wr_flag  in  1  CPU memory write request
- cpu_wr_addr  in  ADDR_W  CPU write address
- cpu_wr_value  in  8  CPU write data
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory write address
- mem_wdata  out  8  memory write data
- cpu_reset  out  1  active-high reset to CPU
- state  out  2  0 IDLE, 1 LOAD, 2 RUN, 3 HALT
- done  out  1  high in HALT
- err  out  1  one-cycle pulse: illegal load_len
- run_cycles  out  CNT_W  cycles spent in RUN, saturating

Behaviour:
- RESET asserted (any time, async): state=IDLE, load counter=0, latched length=0, run_cycles=0, err=0. While in IDLE: cpu_reset=1, in_ready=0, mem_we=0, done=0.
- cpu_reset=1 in IDLE and LOAD, 0 in RUN and HALT (decoded from state, no extra register).
- IDLE:
  - start with 1 ≤ load_len ≤ MEMSIZE → LOAD next cycle; latch len; cnt=0; run_cycles=0.
  - start with load_len=0 or load_len>MEMSIZE → err=1 for exactly the next cycle; stay IDLE.
- LOAD:
  - in_ready=1.
  - On accept: mem_we=1, mem_addr=cnt, mem_wdata=in_data, same cycle (combinational); cnt++ at the edge.
  - Accepting byte len-1 → RUN next cycle; cnt returns to 0.
  - in_valid low stalls indefinitely, no timeout.
  - start is ignored.
  - CPU write inputs are ignored (mem_we comes only from the loader).
- RUN:
  - in_ready=0.
  - mem_we=cpu_wr_flag, mem_addr=cpu_wr_addr, mem_wdata=cpu_wr_value, pass-through with zero latency.
  - run_cycles increments each cycle, saturating at all-ones.
  - cpu_halt=1 → HALT next cycle; a CPU write in that same cycle is still passed through.
  - start is ignored.
- HALT:
  - done=1, mem_we=0 regardless of cpu_wr_flag, run_cycles frozen, in_ready=0.
  - start with legal len → LOAD (cpu_reset reasserts that cycle, run_cycles=0).
  - start with illegal len → err pulse, stay HALT.
- Addresses beyond len are never written during LOAD and keep prior contents.
- Outputs mem_addr/mem_wdata are don't-care when mem_we=0 but must not be X after reset: drive 0.
- No path from in_* to memory outside LOAD; no path from cpu_wr_* to memory outside RUN.

Test Plan:
- Async reset mid-LOAD after 3 of 10 bytes: RESET pulse between clock edges → state=0 immediately, cpu_reset=1, in_ready=0. New start with len=4 writes addresses 0..3 from cnt=0.
- Load len=4, bytes 0x40,0x01,0x50,0x02 with in_valid gapped (1,0,1,1,0,1) → mem_we only on accepts, addresses 0,1,2,3 in order. state=2 and cpu_reset=0 on the cycle after the 4th accept.
- Illegal lengths: start with len=0, then len=65 → err high exactly one cycle each, state stays 0, no mem_we.
- RUN arbitration: in RUN, cpu_wr_flag=1 addr=63 data=0x01 → mem_we=1, mem_addr=63, mem_wdata=0x01 same cycle. Simultaneously in_valid=1 → in_ready=0, loader byte ignored.
- Halt: 20 cycles in RUN then cpu_halt with cpu_wr_flag=1 → that write passes. Next cycle state=3, done=1, run_cycles=20. Further cpu_wr_flag → mem_we=0.
- Reload from HALT: start len=64 → cpu_reset=1, run_cycles=0, full 64-byte load ending at addr 63, then RUN. Saturation: force CNT_W=4, run 20 cycles → run_cycles=15.
